instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Fetch stage that sits directly upstream of the instruction memory: owns the program counter, drives the memory's combinational read address, and captures the returned instruction into an output register. It hands instructions to the decode stage over a valid/ready handshake. It supports branch/jump redirect with flush, halts on a HALT opcode, and keeps a saturating fetch counter.

Parameters:
PC_W, 4, program counter / memory address width
INSTR_W, 4, instruction word width
RESET_PC, 0, PC value loaded on reset
HALT_OPCODE, 4'b1111, instruction value that halts fetching
CNT_W, 8, width of fetch_count

Ports:
clk  in  1  rising-edge clock
reset  in  1  reset, asynchronous, active-high
imem_addr  out  PC_W  read address to instruction memory; equals pc_q
imem_data  in  INSTR_W  combinational read data for imem_addr
redirect_valid  in  1  load redirect_pc this cycle and flush
redirect_pc  in  PC_W  branch/jump target
out_valid  out  1  out_instr/out_pc hold a valid instruction
out_ready  in  1  decode accepts when out_valid && out_ready at an edge
out_instr  out  INSTR_W  fetched instruction
out_pc  out  PC_W  address out_instr was fetched from
halted  out  1  fetch stopped after delivering HALT_OPCODE
fetch_count  out  CNT_W  instructions captured since reset, saturating

Behaviour:
- Reset (async, immediate): pc_q=RESET_PC, state=START, out_valid=0, out_instr=0, out_pc=0, halted=0, fetch_count=0.
- States: START, FETCH, HALTED. halted = (state==HALTED).
- START: the first edge after reset release moves the state to FETCH with no capture. This gives memory contents one cycle to settle after reset.
- Capture condition: state==FETCH && !redirect_valid && (!out_valid || out_ready).
- On capture:
  - out_instr<=imem_data, out_pc<=pc_q, out_valid<=1.
  - pc_q<=pc_q+1 modulo 2^PC_W, so 15 wraps to 0.
  - fetch_count increments and saturates at all-ones.
- If imem_data==HALT_OPCODE on capture: the HALT word is still delivered, fetch_count still increments, state->HALTED, and pc_q is held at the HALT address rather than incremented.
- Without capture: if out_valid && out_ready then out_valid<=0; otherwise the output registers hold. Outputs must be stable while out_valid && !out_ready.
- Latency: an instruction at pc_q appears on out_instr one edge after capture. With out_ready held at 1, throughput is one instruction per cycle.
- Redirect (highest priority, any state except reset):
  - pc_q<=redirect_pc, out_valid<=0 (flush), state<=FETCH; this clears halted.
  - No capture occurs in that cycle.
  - If out_valid && out_ready in the same cycle, that transfer counts as completed for decode; the fetch unit simply clears out_valid.
  - Redirect in START is also legal and moves the state to FETCH.
- HALTED: no captures and pc_q frozen. The pending HALT word drains normally via handshake. Leaves HALTED only on redirect or reset.
- Reset mid-operation: all state clears asynchronously and the sequence restarts at START.

Decomposition:
- Shared package cpu_pkg: PC_W, INSTR_W, HALT_OPCODE defaults, fetch state enum (START/FETCH/HALTED).
- One sub-module, sat_counter (parameter W; inputs clk, reset, inc; output count), used for fetch_count.
- PC, state and output register remain in instr_fetch_unit.

Test Plan:
The bench memory model holds 0:0001 1:0010 2:0100 3:0110 4:1000 5:1010 6:1100 7:1111, with all other locations 0011.

1. Release reset, out_ready=1 -> out_valid first high 2 edges after release. out_instr is 0001,0010,0100,0110,1000,1010,1100,1111 with out_pc 0..7 on consecutive cycles. halted=1 after the 1111 capture, out_valid drops next cycle, fetch_count=8, imem_addr stays 7.
2. Stall: hold out_ready=0 while out_pc=2 is valid, for 3 cycles -> out_instr=0100 stable, imem_addr=3 stable, fetch_count unchanged. Raise out_ready -> next out_pc=3, out_instr=0110.
3. Redirect: pulse redirect_valid with redirect_pc=5 while out_pc=1 is valid and out_ready=0 -> next cycle out_valid=0, imem_addr=5. Following cycle out_instr=1010, out_pc=5.
4. Wrap: redirect to 14 -> delivered out_pc sequence 14,15,0,1 with instrs 0011,0011,0001,0010.
5. Halt recovery: once halted=1, redirect_pc=0 -> halted=0 next cycle and the sequence restarts from 0001. With CNT_W=4, fetch_count saturates at 15 and does not wrap.
6. Async reset mid-stream: assert reset between edges while out_valid=1 and out_pc=4 -> out_valid, out_pc, fetch_count and halted read 0 immediately. After release, the sequence restarts exactly as in test 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared definitions for the front end of the CPU: default widths, the
//   halt opcode and the fetch state encoding.
package cpu_pkg;

   localparam int          PC_W_DEF        = 4;
   localparam int          INSTR_W_DEF     = 4;
   localparam int          CNT_W_DEF       = 8;
   localparam logic [3:0]  HALT_OPCODE_DEF = 4'b1111;

   // START  : one settle cycle after reset release, no capture
   // FETCH  : normal fetching
   // HALTED : HALT word captured, fetching frozen until redirect/reset
   typedef enum logic [1:0] {
      ST_START  = 2'd0,
      ST_FETCH  = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Up counter that sticks at all-ones instead of wrapping.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears count
//   inc   : increment request for this cycle
//   count : current value
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage in front of a combinational instruction memory. Owns the PC,
//   presents it as the memory read address, registers the returned word and
//   hands it to decode over a valid/ready handshake. Supports redirect with
//   flush, stops after delivering HALT_OPCODE and counts captures.
//
//   Ports
//     clk, reset      : rising-edge clock, asynchronous active-high reset
//     imem_addr       : memory read address (always pc_q)
//     imem_data       : memory read data for imem_addr
//     redirect_valid  : load redirect_pc, flush the output register
//     redirect_pc     : branch/jump target
//     out_valid       : out_instr/out_pc hold a valid instruction
//     out_ready       : decode accepts
//     out_instr       : fetched instruction
//     out_pc          : address out_instr came from
//     halted          : fetch stopped after HALT was captured
//     fetch_count     : saturating count of captures since reset
//
//   Handshake: a transfer happens at a rising edge where out_valid and
//   out_ready are both high. While out_valid is high and out_ready is low,
//   out_instr and out_pc do not change. out_valid never depends
//   combinationally on out_ready.
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int                 PC_W        = PC_W_DEF,
   parameter int                 INSTR_W     = INSTR_W_DEF,
   parameter logic [PC_W-1:0]    RESET_PC    = '0,
   parameter logic [INSTR_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF,
   parameter int                 CNT_W       = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc,
   output logic               halted,
   output logic [CNT_W-1:0]   fetch_count
);

   fetch_state_t     state_q;
   logic [PC_W-1:0]  pc_q;
   logic             capture;
   logic             is_halt;

   // Capture only when the output slot is empty or being drained this edge.
   assign capture = (state_q == ST_FETCH) && !redirect_valid &&
                    (!out_valid || out_ready);
   assign is_halt = (imem_data == HALT_OPCODE);

   assign imem_addr = pc_q;
   assign halted    = (state_q == ST_HALTED);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_START;
         pc_q      <= RESET_PC;
         out_valid <= 1'b0;
         out_instr <= '0;
         out_pc    <= '0;
      end else if (redirect_valid) begin
         // Flush: any word in flight is dropped (or was just taken by decode).
         state_q   <= ST_FETCH;
         pc_q      <= redirect_pc;
         out_valid <= 1'b0;
      end else begin
         case (state_q)
            ST_START: begin
               state_q <= ST_FETCH;
            end
            ST_FETCH: begin
               if (capture) begin
                  out_instr <= imem_data;
                  out_pc    <= pc_q;
                  out_valid <= 1'b1;
                  if (is_halt) begin
                     // PC parks on the HALT address.
                     state_q <= ST_HALTED;
                  end else begin
                     pc_q <= pc_q + 1'b1;
                  end
               end else if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            ST_HALTED: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_START;
            end
         endcase
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_fetch_count (
      .clk   (clk),
      .reset (reset),
      .inc   (capture),
      .count (fetch_count)
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit with a 16-entry memory model.
//   fetch_count is built 4 bits wide so saturation is reachable.
module tb_instr_fetch_unit;

   logic       clk;
   logic       reset;
   logic [3:0] imem_addr;
   logic [3:0] imem_data;
   logic       redirect_valid;
   logic [3:0] redirect_pc;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_instr;
   logic [3:0] out_pc;
   logic       halted;
   logic [3:0] fetch_count;

   int errors;
   int checks;

   logic [3:0] mem_model [16];

   instr_fetch_unit #(
      .PC_W        (4),
      .INSTR_W     (4),
      .RESET_PC    (4'd0),
      .HALT_OPCODE (4'b1111),
      .CNT_W       (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .halted         (halted),
      .fetch_count    (fetch_count)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb imem_data = mem_model[imem_addr];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic hold_reset();
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 4'd0;
      out_ready      = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   // Runs the stored program from reset release with out_ready=1.
   task automatic run_program(input string tag);
      logic [3:0] exp_instr [8];
      exp_instr = '{4'b0001, 4'b0010, 4'b0100, 4'b0110,
                    4'b1000, 4'b1010, 4'b1100, 4'b1111};
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_settle_valid: got %0b expected 0", tag, out_valid);
      end
      step();
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 4'(i) || out_instr !== exp_instr[i]) begin
            errors++;
            $display("FAIL %s_seq[%0d]: got v=%0b pc=%0d instr=%b expected v=1 pc=%0d instr=%b",
                     tag, i, out_valid, out_pc, out_instr, i, exp_instr[i]);
         end
         checks++;
         if (halted !== (i == 7)) begin
            errors++;
            $display("FAIL %s_halted[%0d]: got %0b expected %0b", tag, i, halted, (i == 7));
         end
         step();
      end
      checks++;
      if (out_valid !== 1'b0 || halted !== 1'b1 || fetch_count !== 4'd8 || imem_addr !== 4'd7) begin
         errors++;
         $display("FAIL %s_end: got v=%0b h=%0b cnt=%0d addr=%0d expected v=0 h=1 cnt=8 addr=7",
                  tag, out_valid, halted, fetch_count, imem_addr);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 4'd0;
      out_ready = 1'b1;
      #3;
      checks++;
      if (out_valid !== 1'b0 || out_instr !== 4'd0 || out_pc !== 4'd0 ||
          halted !== 1'b0 || fetch_count !== 4'd0 || imem_addr !== 4'd0) begin
         errors++;
         $display("FAIL reset_state: got v=%0b i=%b pc=%0d h=%0b cnt=%0d addr=%0d expected all 0",
                  out_valid, out_instr, out_pc, halted, fetch_count, imem_addr);
      end
   endtask

   task automatic test_stream();
      hold_reset();
      run_program("stream");
   endtask

   task automatic test_stall();
      hold_reset();
      step();
      step();
      step();
      step();
      checks++;
      if (out_pc !== 4'd2 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL stall_setup: got pc=%0d v=%0b expected pc=2 v=1", out_pc, out_valid);
      end
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || out_instr !== 4'b0100 || out_pc !== 4'd2 ||
             imem_addr !== 4'd3 || fetch_count !== 4'd3) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got v=%0b i=%b pc=%0d addr=%0d cnt=%0d expected v=1 i=0100 pc=2 addr=3 cnt=3",
                     k, out_valid, out_instr, out_pc, imem_addr, fetch_count);
         end
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 4'd3 || out_instr !== 4'b0110) begin
         errors++;
         $display("FAIL stall_release: got v=%0b pc=%0d i=%b expected v=1 pc=3 i=0110",
                  out_valid, out_pc, out_instr);
      end
   endtask

   // Redirect, wrap and halt recovery run as one continuous stream so
   // fetch_count reaches saturation.
   task automatic test_redirect();
      hold_reset();
      step();
      step();
      step();
      checks++;
      if (out_pc !== 4'd1 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL redir_setup: got pc=%0d v=%0b expected pc=1 v=1", out_pc, out_valid);
      end
      out_ready      = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 4'd5;
      step();
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      checks++;
      if (out_valid !== 1'b0 || imem_addr !== 4'd5) begin
         errors++;
         $display("FAIL redir_flush: got v=%0b addr=%0d expected v=0 addr=5", out_valid, imem_addr);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_instr !== 4'b1010 || out_pc !== 4'd5) begin
         errors++;
         $display("FAIL redir_target: got v=%0b i=%b pc=%0d expected v=1 i=1010 pc=5",
                  out_valid, out_instr, out_pc);
      end
   endtask

   task automatic test_wrap();
      logic [3:0] exp_pc [4];
      logic [3:0] exp_in [4];
      exp_pc = '{4'd14, 4'd15, 4'd0, 4'd1};
      exp_in = '{4'b0011, 4'b0011, 4'b0001, 4'b0010};
      redirect_valid = 1'b1;
      redirect_pc    = 4'd14;
      step();
      redirect_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || imem_addr !== 4'd14) begin
         errors++;
         $display("FAIL wrap_flush: got v=%0b addr=%0d expected v=0 addr=14", out_valid, imem_addr);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || out_pc !== exp_pc[i] || out_instr !== exp_in[i]) begin
            errors++;
            $display("FAIL wrap_seq[%0d]: got v=%0b pc=%0d i=%b expected v=1 pc=%0d i=%b",
                     i, out_valid, out_pc, out_instr, exp_pc[i], exp_in[i]);
         end
      end
   endtask

   task automatic test_halt_recovery();
      // Continue from pc 2 up to the HALT word at 7.
      for (int i = 0; i < 6; i++) step();
      checks++;
      if (halted !== 1'b1 || out_pc !== 4'd7 || out_instr !== 4'b1111 || fetch_count !== 4'd13) begin
         errors++;
         $display("FAIL halt_reach: got h=%0b pc=%0d i=%b cnt=%0d expected h=1 pc=7 i=1111 cnt=13",
                  halted, out_pc, out_instr, fetch_count);
      end
      redirect_valid = 1'b1;
      redirect_pc    = 4'd0;
      step();
      redirect_valid = 1'b0;
      checks++;
      if (halted !== 1'b0 || out_valid !== 1'b0 || imem_addr !== 4'd0) begin
         errors++;
         $display("FAIL halt_leave: got h=%0b v=%0b addr=%0d expected h=0 v=0 addr=0",
                  halted, out_valid, imem_addr);
      end
      step();
      checks++;
      if (out_instr !== 4'b0001 || out_pc !== 4'd0 || fetch_count !== 4'd14) begin
         errors++;
         $display("FAIL halt_restart0: got i=%b pc=%0d cnt=%0d expected i=0001 pc=0 cnt=14",
                  out_instr, out_pc, fetch_count);
      end
      step();
      checks++;
      if (out_instr !== 4'b0010 || fetch_count !== 4'd15) begin
         errors++;
         $display("FAIL halt_restart1: got i=%b cnt=%0d expected i=0010 cnt=15", out_instr, fetch_count);
      end
      step();
      step();
      checks++;
      if (out_instr !== 4'b0110 || fetch_count !== 4'd15) begin
         errors++;
         $display("FAIL count_saturate: got i=%b cnt=%0d expected i=0110 cnt=15", out_instr, fetch_count);
      end
   endtask

   task automatic test_async_reset();
      hold_reset();
      for (int i = 0; i < 6; i++) step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 4'd4) begin
         errors++;
         $display("FAIL areset_setup: got v=%0b pc=%0d expected v=1 pc=4", out_valid, out_pc);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_pc !== 4'd0 || fetch_count !== 4'd0 ||
          halted !== 1'b0 || imem_addr !== 4'd0) begin
         errors++;
         $display("FAIL areset_immediate: got v=%0b pc=%0d cnt=%0d h=%0b addr=%0d expected all 0",
                  out_valid, out_pc, fetch_count, halted, imem_addr);
      end
      step();
      reset = 1'b0;
      run_program("areset");
   endtask

   // ---------------- main ----------------
   initial begin
      errors = 0;
      checks = 0;
      for (int a = 0; a < 16; a++) mem_model[a] = 4'b0011;
      mem_model[0] = 4'b0001;
      mem_model[1] = 4'b0010;
      mem_model[2] = 4'b0100;
      mem_model[3] = 4'b0110;
      mem_model[4] = 4'b1000;
      mem_model[5] = 4'b1010;
      mem_model[6] = 4'b1100;
      mem_model[7] = 4'b1111;

      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_wrap();
      test_halt_recovery();
      test_async_reset();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
